// File: rtl/waveform_analyzer_pkg.sv
// waveform_analyzer_pkg
//   Shared definitions for the waveform analyzer slice: the request FSM
//   state encoding and the response watchdog length.
package waveform_analyzer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE          = 2'd0,
        ST_WAIT_INTERVAL = 2'd1,
        ST_WAIT_RESP     = 2'd2
    } req_state_e;

    // Cycles after the request cycle in which a response is still accepted.
    localparam int unsigned TIMEOUT_CYCLES = 16;
    // Watchdog counter width; must hold TIMEOUT_CYCLES.
    localparam int unsigned WDOG_W = 5;

endpackage

// File: rtl/waveform_analyzer_if.sv
// waveform_analyzer_if
//   Strobe protocol between the waveform generator and the analyzer.
//   next_data_strobe_o  : one-cycle request, driven by the analyzer
//   data_i              : signed sample (N_FRAC+1 bits), driven by the generator
//   data_valid_strobe_i : one-cycle sample valid, driven by the generator
//   Modports: master = analyzer (requester), slave = generator (responder).
interface waveform_analyzer_if #(
    parameter int N_FRAC = 7
);
    logic                     next_data_strobe_o;
    logic signed [N_FRAC:0]   data_i;
    logic                     data_valid_strobe_i;

    modport master (
        output next_data_strobe_o,
        input  data_i,
        input  data_valid_strobe_i
    );

    modport slave (
        input  next_data_strobe_o,
        output data_i,
        output data_valid_strobe_i
    );
endinterface

// File: rtl/waveform_analyzer_sample_requester.sv
// sample_requester
//   Request engine: waits interval_i idle cycles, issues a one-cycle request
//   strobe, then waits for the response and flags its acceptance.
//   Ports:
//     clk_i, rst_i (async, active-low)
//     enable_i    : run the request engine
//     interval_i  : idle cycles between a response and the next request
//     valid_i     : response valid strobe from the generator
//     strobe_o    : registered one-cycle request strobe
//     accept_o    : combinational, high in the cycle a response is accepted
//     timeout_o   : sticky missing-response flag
//   Optional: WAVEFORM_ANALYZER_TIMEOUT_EN adds a response watchdog;
//   without it the engine waits for a response indefinitely.
module sample_requester
    import waveform_analyzer_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic [DIV_W-1:0] interval_i,
    input  logic             valid_i,
    output logic             strobe_o,
    output logic             accept_o,
    output logic             timeout_o
);

    req_state_e       state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             strobe_q, strobe_d;
    logic             done;

`ifdef WAVEFORM_ANALYZER_TIMEOUT_EN
    logic [WDOG_W-1:0] wd_q, wd_d;
    logic              timeout_q;
    logic              expire;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        strobe_d = 1'b0;
        accept_o = 1'b0;
        done     = 1'b0;
`ifdef WAVEFORM_ANALYZER_TIMEOUT_EN
        wd_d     = wd_q;
        expire   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (enable_i) begin
                    state_d = ST_WAIT_INTERVAL;
                    cnt_d   = interval_i;
                end
            end
            ST_WAIT_INTERVAL: begin
                if (!enable_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    state_d  = ST_WAIT_RESP;
                    strobe_d = 1'b1;
`ifdef WAVEFORM_ANALYZER_TIMEOUT_EN
                    wd_d     = '0;
`endif
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            ST_WAIT_RESP: begin
                // strobe_q marks the request cycle, where a valid is ignored
                accept_o = valid_i && !strobe_q;
`ifdef WAVEFORM_ANALYZER_TIMEOUT_EN
                // wd_q equals the number of cycles since the request cycle
                wd_d   = wd_q + WDOG_W'(1);
                expire = !accept_o && (wd_q == WDOG_W'(TIMEOUT_CYCLES));
                done   = accept_o || expire;
`else
                done   = accept_o;
`endif
                // disabling never aborts a request; it only takes effect here
                if (done) begin
                    if (enable_i) begin
                        state_d = ST_WAIT_INTERVAL;
                        cnt_d   = interval_i;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            strobe_q <= 1'b0;
`ifdef WAVEFORM_ANALYZER_TIMEOUT_EN
            wd_q      <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            strobe_q <= strobe_d;
`ifdef WAVEFORM_ANALYZER_TIMEOUT_EN
            wd_q      <= wd_d;
            timeout_q <= timeout_q | expire;
`endif
        end
    end

    assign strobe_o = strobe_q;

`ifdef WAVEFORM_ANALYZER_TIMEOUT_EN
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: rtl/waveform_analyzer.sv
// waveform_analyzer
//   Requests samples from the waveform generator at a programmable spacing
//   and measures the signal period (samples between rising zero crossings)
//   plus the peak max/min over each period.
//   Ports:
//     clk_i, rst_i (async, active-low)
//     enable_i              : run the request engine
//     interval_i            : idle cycles between a response and next request
//     gen (master modport)  : next_data_strobe_o / data_i / data_valid_strobe_i
//     period_o              : samples in the last completed period (saturating)
//     peak_max_o/peak_min_o : signed extremes over the last completed period
//     result_valid_strobe_o : one-cycle pulse when the results update
//     timeout_o             : sticky missing-response flag
//   Optional: WAVEFORM_ANALYZER_TIMEOUT_EN enables the response watchdog.
module waveform_analyzer
    import waveform_analyzer_pkg::*;
#(
    parameter int N_FRAC   = 7,
    parameter int DIV_W    = 8,
    parameter int PERIOD_W = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   enable_i,
    input  logic [DIV_W-1:0]       interval_i,
    waveform_analyzer_if.master    gen,
    output logic [PERIOD_W-1:0]    period_o,
    output logic signed [N_FRAC:0] peak_max_o,
    output logic signed [N_FRAC:0] peak_min_o,
    output logic                   result_valid_strobe_o,
    output logic                   timeout_o
);

    logic                   accept;
    logic signed [N_FRAC:0] cur;
    logic signed [N_FRAC:0] prev_q;
    logic                   have_prev_q;
    logic                   armed_q;
    logic [PERIOD_W-1:0]    win_cnt_q;
    logic signed [N_FRAC:0] win_max_q;
    logic signed [N_FRAC:0] win_min_q;
    logic                   crossing;

    sample_requester #(
        .DIV_W (DIV_W)
    ) u_requester (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .enable_i   (enable_i),
        .interval_i (interval_i),
        .valid_i    (gen.data_valid_strobe_i),
        .strobe_o   (gen.next_data_strobe_o),
        .accept_o   (accept),
        .timeout_o  (timeout_o)
    );

    assign cur = gen.data_i;

    // Rising crossing: prev < 0 and cur >= 0, read straight from the sign bits.
    assign crossing = have_prev_q && prev_q[N_FRAC] && !cur[N_FRAC];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            prev_q                <= '0;
            have_prev_q           <= 1'b0;
            armed_q               <= 1'b0;
            win_cnt_q             <= '0;
            win_max_q             <= '0;
            win_min_q             <= '0;
            period_o              <= '0;
            peak_max_o            <= '0;
            peak_min_o            <= '0;
            result_valid_strobe_o <= 1'b0;
        end else begin
            result_valid_strobe_o <= 1'b0;
            if (accept) begin
                have_prev_q <= 1'b1;
                prev_q      <= cur;
                if (crossing) begin
                    // Publish the window that ended on the previous sample,
                    // then open a new one that includes the crossing sample.
                    if (armed_q) begin
                        period_o              <= win_cnt_q;
                        peak_max_o            <= win_max_q;
                        peak_min_o            <= win_min_q;
                        result_valid_strobe_o <= 1'b1;
                    end
                    armed_q   <= 1'b1;
                    win_cnt_q <= PERIOD_W'(1);
                    win_max_q <= cur;
                    win_min_q <= cur;
                end else if (armed_q) begin
                    if (win_cnt_q != '1) begin
                        win_cnt_q <= win_cnt_q + PERIOD_W'(1);
                    end
                    if (cur > win_max_q) begin
                        win_max_q <= cur;
                    end
                    if (cur < win_min_q) begin
                        win_min_q <= cur;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_waveform_analyzer.sv
// tb_waveform_analyzer
//   Self-checking bench for waveform_analyzer: a sawtooth vector table,
//   hand-written corner sequences (ignored strobes, disable, timeout, async
//   reset) and randomized transactions against a queue-based period model.
//   Honours WAVEFORM_ANALYZER_TIMEOUT_EN to pick the matching timeout checks.
module tb_waveform_analyzer;

    localparam int N_FRAC   = 7;
    localparam int DIV_W    = 8;
    localparam int PERIOD_W = 16;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   enable;
    logic [DIV_W-1:0]       interval;
    logic [PERIOD_W-1:0]    period;
    logic signed [N_FRAC:0] peak_max;
    logic signed [N_FRAC:0] peak_min;
    logic                   rv;
    logic                   timeout;

    always #5 clk = ~clk;

    waveform_analyzer_if #(.N_FRAC(N_FRAC)) bus ();

    waveform_analyzer #(
        .N_FRAC   (N_FRAC),
        .DIV_W    (DIV_W),
        .PERIOD_W (PERIOD_W)
    ) dut (
        .clk_i                 (clk),
        .rst_i                 (rst_n),
        .enable_i              (enable),
        .interval_i            (interval),
        .gen                   (bus),
        .period_o              (period),
        .peak_max_o            (peak_max),
        .peak_min_o            (peak_min),
        .result_valid_strobe_o (rv),
        .timeout_o             (timeout)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model (sample-list level) ----------------
    bit m_have_prev;
    bit m_armed;
    int m_prev;
    int m_period;
    int m_max;
    int m_min;
    int m_win[$];

    task automatic model_reset();
        m_have_prev = 0;
        m_armed     = 0;
        m_prev      = 0;
        m_period    = 0;
        m_max       = 0;
        m_min       = 0;
        m_win.delete();
    endtask

    task automatic model_accept(input int cur, output int exp_rv);
        exp_rv = 0;
        if (m_have_prev && m_prev < 0 && cur >= 0) begin
            if (m_armed) begin
                m_period = m_win.size();
                m_max    = m_win[0];
                m_min    = m_win[0];
                foreach (m_win[i]) begin
                    if (m_win[i] > m_max) m_max = m_win[i];
                    if (m_win[i] < m_min) m_min = m_win[i];
                end
                exp_rv = 1;
            end
            m_armed = 1;
            m_win.delete();
        end
        if (m_armed) m_win.push_back(cur);
        m_have_prev = 1;
        m_prev      = cur;
    endtask

    // ---------------- request spacing tracking ----------------
    int last_strobe = 0;
    int exp_gap     = 0;

    task automatic wait_strobe();
        int n = 0;
        while (bus.next_data_strobe_o !== 1'b1 && n < 400) begin
            step();
            n++;
        end
        chk("strobe_seen", int'(bus.next_data_strobe_o), 1);
        if (exp_gap != 0) chk("req_gap", cyc - last_strobe, exp_gap);
        last_strobe = cyc;
        exp_gap     = 0;
    endtask

    // One request/response: respond lat cycles after the strobe with sample,
    // presenting iv on interval_i in the accept cycle (the reload point).
    task automatic xact(input int sample, input int lat, input int iv,
                        input bit spur, input bit dis,
                        output int a_rv, output int a_per,
                        output int a_max, output int a_min, output int e_rv);
        int extra = 0;
        wait_strobe();
        if (spur) begin
            bus.data_valid_strobe_i = 1'b1;
            bus.data_i              = 8'sd100;
        end
        for (int k = 1; k <= lat; k++) begin
            step();
            bus.data_valid_strobe_i = 1'b0;
            if (bus.next_data_strobe_o === 1'b1) extra++;
            if (k == 1 && spur) chk("spur_ignored_rv", int'(rv), 0);
            if (k == 1 && dis) enable = 1'b0;
            if (k == lat) begin
                bus.data_valid_strobe_i = 1'b1;
                bus.data_i              = (N_FRAC+1)'(sample);
                interval                = DIV_W'(iv);
            end
        end
        step();
        bus.data_valid_strobe_i = 1'b0;
        a_rv  = int'(rv);
        a_per = int'(period);
        a_max = peak_max;
        a_min = peak_min;
        // interval_i changes mid-count must have no effect
        interval = DIV_W'($urandom_range(20));
        chk("req_once", extra, 0);
        model_accept(sample, e_rv);
        exp_gap = enable ? lat + iv + 2 : 0;
    endtask

    typedef struct {
        int sample;
        int rv;
        int per;
        int mx;
        int mn;
    } vec_t;

    vec_t tbl[9];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "time limit");
    end

    initial begin
        int a_rv, a_per, a_max, a_min, e_rv;
        int s, n, cnt_req, cnt_rv;
        int rst_seq[6];

        tbl[0] = '{-4, 0, 0, 0, 0};
        tbl[1] = '{-2, 0, 0, 0, 0};
        tbl[2] = '{ 0, 0, 0, 0, 0};
        tbl[3] = '{ 2, 0, 0, 0, 0};
        tbl[4] = '{-4, 0, 0, 0, 0};
        tbl[5] = '{-2, 0, 0, 0, 0};
        tbl[6] = '{ 0, 1, 4, 2, -4};
        tbl[7] = '{ 2, 0, 4, 2, -4};
        tbl[8] = '{-4, 0, 4, 2, -4};
        rst_seq = '{-4, -2, 0, 2, -4, -2};

        rst_n                   = 1'b0;
        enable                  = 1'b0;
        interval                = '0;
        bus.data_i              = '0;
        bus.data_valid_strobe_i = 1'b0;
        model_reset();
        repeat (3) step();
        chk("rst_period", int'(period), 0);
        chk("rst_max", int'(peak_max), 0);
        chk("rst_min", int'(peak_min), 0);
        chk("rst_rv", int'(rv), 0);
        chk("rst_timeout", int'(timeout), 0);
        chk("rst_strobe", int'(bus.next_data_strobe_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // sawtooth table, interval 3, latency 1 -> strobes every 6 cycles
        enable   = 1'b1;
        interval = 8'd3;
        for (int i = 0; i < 9; i++) begin
            xact(tbl[i].sample, 1, 3, 0, 0, a_rv, a_per, a_max, a_min, e_rv);
            chk($sformatf("tbl%0d_rv", i), a_rv, tbl[i].rv);
            chk($sformatf("tbl%0d_period", i), a_per, tbl[i].per);
            chk($sformatf("tbl%0d_max", i), a_max, tbl[i].mx);
            chk($sformatf("tbl%0d_min", i), a_min, tbl[i].mn);
        end

        // valid in the request cycle ignored, valid on the next cycle accepted
        xact(-3, 1, 3, 1, 0, a_rv, a_per, a_max, a_min, e_rv);
        chk("spur_rv", a_rv, e_rv);
        chk("spur_period", a_per, m_period);

        // disable during WAIT_RESP: response still accepted, then idle
        xact(-5, 2, 3, 0, 1, a_rv, a_per, a_max, a_min, e_rv);
        chk("dis_rv", a_rv, e_rv);
        cnt_req = 0;
        cnt_rv  = 0;
        for (int i = 0; i < 20; i++) begin
            bus.data_valid_strobe_i = (i == 5);
            bus.data_i              = 8'sd50;
            step();
            if (bus.next_data_strobe_o === 1'b1) cnt_req++;
            if (rv === 1'b1) cnt_rv++;
        end
        bus.data_valid_strobe_i = 1'b0;
        chk("idle_no_req", cnt_req, 0);
        chk("idle_valid_ignored", cnt_rv, 0);
        chk("idle_period", int'(period), m_period);
        enable   = 1'b1;
        interval = 8'd3;
        exp_gap  = 0;

`ifdef WAVEFORM_ANALYZER_TIMEOUT_EN
        // response in the 16th cycle after the request is still accepted
        xact(-6, 16, 2, 0, 0, a_rv, a_per, a_max, a_min, e_rv);
        chk("late16_rv", a_rv, e_rv);
        chk("late16_no_timeout", int'(timeout), 0);
        interval = 8'd2;
        wait_strobe();
        s = cyc;
        n = 0;
        while (timeout !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk("timeout_latency", cyc - s, 17);
        exp_gap = 16 + 2 + 2;
        xact(-7, 1, 3, 0, 0, a_rv, a_per, a_max, a_min, e_rv);
        chk("after_timeout_rv", a_rv, e_rv);
        chk("timeout_sticky", int'(timeout), 1);
`else
        // no watchdog: a 40-cycle response delay is simply waited out
        xact(-6, 40, 3, 0, 0, a_rv, a_per, a_max, a_min, e_rv);
        chk("slow_rv", a_rv, e_rv);
        chk("slow_period", a_per, m_period);
        chk("no_timeout", int'(timeout), 0);
`endif

        // randomized transactions against the model
        for (int i = 0; i < 150; i++) begin
            int smp, lat, iv;
            smp = int'($urandom_range(40)) - 20;
            lat = int'($urandom_range(5, 1));
            iv  = int'($urandom_range(5));
            xact(smp, lat, iv, 0, 0, a_rv, a_per, a_max, a_min, e_rv);
            chk("rnd_rv", a_rv, e_rv);
            chk("rnd_period", a_per, m_period);
            chk("rnd_max", a_max, m_max);
            chk("rnd_min", a_min, m_min);
        end
        wait_strobe();

        // async reset between edges while the request strobe is high
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_strobe", int'(bus.next_data_strobe_o), 0);
        chk("arst_period", int'(period), 0);
        chk("arst_max", int'(peak_max), 0);
        chk("arst_min", int'(peak_min), 0);
        chk("arst_rv", int'(rv), 0);
        chk("arst_timeout", int'(timeout), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        exp_gap  = 0;
        interval = 8'd3;
        step();
        for (int i = 0; i < 6; i++) begin
            xact(rst_seq[i], 1, 3, 0, 0, a_rv, a_per, a_max, a_min, e_rv);
            chk($sformatf("post_rst%0d_rv", i), a_rv, 0);
            chk($sformatf("post_rst%0d_period", i), a_per, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/waveform_analyzer.md
# waveform_analyzer

Consumer end of the waveform generator's strobe protocol: it issues `next_data_strobe_o` requests at a programmable spacing and accepts the returned sample on `data_valid_strobe_i`. From those samples it measures the signal period, counted in samples between rising zero crossings, plus the peak maximum and minimum over each period. It sits downstream of the sawtooth, triangle or square output of the top-level generator and closes the request/response loop for self-test and monitoring.

## Interface
- `N_FRAC`, 7, fractional bits; sample width is N_FRAC+1, signed
- `DIV_W`, 8, width of the request-interval input
- `PERIOD_W`, 16, width of the period counter and result
- `clk_i`  in  1  single clock, rising edge
- `rst_i`  in  1  reset; asynchronous, active-low
- `enable_i`  in  1  run request engine
- `interval_i`  in  DIV_W  idle cycles between a response and the next request
- `next_data_strobe_o`  out  1  one-cycle request to the generator
- `data_i`  in  N_FRAC+1  signed sample from the generator
- `data_valid_strobe_i`  in  1  sample valid, one cycle
- `period_o`  out  PERIOD_W  samples per period, last completed period
- `peak_max_o`  out  N_FRAC+1  signed maximum over the last completed period
- `peak_min_o`  out  N_FRAC+1  signed minimum over the last completed period
- `result_valid_strobe_o`  out  1  one-cycle pulse when the three results update
- `timeout_o`  out  1  sticky flag: a request got no response

## Operation
- FSM states: IDLE, WAIT_INTERVAL, WAIT_RESP.
  - IDLE: when `enable_i`=1, go to WAIT_INTERVAL and load cnt=`interval_i`.
  - WAIT_INTERVAL: if `enable_i`=0, go to IDLE; else if cnt=0, go to WAIT_RESP; else decrement cnt.
  - WAIT_RESP: `next_data_strobe_o` is registered and high only in the first cycle of WAIT_RESP.
- Sample acceptance: a `data_valid_strobe_i` in any later WAIT_RESP cycle is accepted.
  - After acceptance, go to WAIT_INTERVAL and reload `interval_i`, or go to IDLE if `enable_i`=0.
  - A valid strobe in the request cycle, or in any other state, is ignored.
- Disabling: deasserting `enable_i` in WAIT_RESP does not abort the transaction; it completes, then the FSM goes to IDLE.
- Rising crossing: an accepted sample with prev<0 and cur>=0, signed compare.
  - `have_prev` is cleared at reset, so the first sample never counts as a crossing.
- Window:
  - Starts at a crossing sample, inclusive.
  - Accumulates sample count and running max/min.
  - Counter saturates at 2^PERIOD_W−1.
- Crossing handling:
  - First crossing after reset only arms the measurement.
  - Each later crossing publishes count/max/min from the window just closed, which excludes the current sample.
  - The window then restarts with count=1 and max=min=cur.
- Measurement state survives `enable_i` toggling and is cleared only by reset.

## Timing
- Reset values:
  - All outputs 0.
  - FSM in IDLE, cnt=0, `have_prev`=0, armed=0.
  - Window count=0, window max/min=0.
- Request spacing: if a response arrives L≥1 cycles after the strobe, consecutive strobes are L+`interval_i`+2 cycles apart.
- Result latency: for a crossing sample accepted in cycle t, `period_o`/`peak_*_o` change at the edge ending cycle t, and `result_valid_strobe_o` is high during cycle t+1 only.
- Reset asserted mid-transaction: everything returns to reset values immediately, with no pending strobe.
- `interval_i` is sampled only on reload; changing it mid-count has no effect until the next reload.

## Configuration
- `WAVEFORM_ANALYZER_TIMEOUT_EN` defined:
  - WAIT_RESP runs a 5-bit watchdog.
  - If no valid strobe arrives in the 16 cycles after the request cycle, `timeout_o` is set (sticky until reset) and the FSM leaves as if a response had been accepted, with no sample processed.
  - A valid strobe in the 16th cycle is still accepted, and no timeout is flagged.
- Macro undefined: WAIT_RESP waits indefinitely, and `timeout_o` is tied to 0.

## Structure
- Shared package: FSM state encoding constants and `TIMEOUT_CYCLES`=16.
- One sub-module, `sample_requester`, containing the FSM, interval counter, strobe and watchdog. It exports an accepted-sample strobe to the measurement logic in the top.

## Test plan
- Request spacing: `interval_i`=3, responder latency 1 → `next_data_strobe_o` pulses every 6 cycles, each pulse exactly 1 cycle wide.
- Sawtooth: repeating −4,−2,0,2 → after the second crossing, `period_o`=4, `peak_max_o`=2, `peak_min_o`=−4, with `result_valid_strobe_o` high 1 cycle after the crossing sample.
- Ignored and late strobes: valid in the request cycle is ignored, and a valid while in IDLE is ignored; a valid on the 2nd WAIT_RESP cycle is accepted.
- Disable mid-request: `enable_i`=0 during WAIT_RESP → the response is accepted, then IDLE, and no further strobes.
- Timeout (macro on): responder silent → `timeout_o`=1 after 17 cycles in WAIT_RESP and stays 1, and requests continue. With the macro off, the FSM stays in WAIT_RESP and `timeout_o`=0.
- Async reset mid-window: assert `rst_i`=0 between clock edges → all outputs 0 immediately; the next first crossing only arms, so no result strobe.
